cla_pipelined_adder: RTL
========================

Name: cla_pipelined_adder

Overview:
- Parametrised, pipelined successor to the 4-bit carry lookahead adder.
- Splits a WIDTH-bit add/subtract into 4-bit lookahead blocks, one block per pipeline stage; the carry is registered between stages.
- Accepts one operation per cycle through a valid/ready handshake with backpressure.
- Adds subtract mode, signed-overflow and zero flags.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4, range 4..64; stage count N = WIDTH/4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid this cycle
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (borrow-in when sub=1)
- sub  input  1  0: a+b+c_in; 1: a+~b+(~c_in)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference
- c_out  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow
- zero  output  1  s == 0

Behaviour:
- Single clock domain. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset: all stage valid bits cleared; out_valid=0, s=0, c_out=0, ovf=0, zero=0. in_ready=1 in the cycle after reset. Reset mid-operation discards all in-flight operations; none emerge afterwards.
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b
  - cin_eff = c_in XOR sub
  - sub=1, c_in=0 gives a-b; sub=1, c_in=1 gives a-b-1.
- Stage k (k=0..N-1):
  - Computes block bits [4k+3:4k] with 4-bit generate/propagate lookahead from the carry registered by stage k-1 (stage 0 uses cin_eff).
  - Registers its sum nibble, its block carry-out and the unprocessed upper operand bits.
  - Completed lower nibbles are skew-registered forward so the full result aligns at the output.
- Global advance signal: advance = !out_valid || out_ready. in_ready = advance. The transfer occurs when in_valid && in_ready. When advance=0, every stage, including the output, holds its state.
- Latency:
  - An accepted operation appears with out_valid=1 exactly N cycles after acceptance when no stall occurs; stalls add one cycle each.
  - Throughput is 1 op/cycle.
  - Bubbles propagate as invalid stages; they do not block later valid operations.
- Outputs are registered and change only on advance. While out_valid && !out_ready, s/c_out/ovf/zero are held stable.
- Flags are computed in the final stage:
  - ovf = carry into MSB XOR carry out of MSB
  - zero = (s == 0)
  - c_out = raw carry out of MSB, not inverted in sub mode.
- Ordering: results emerge in acceptance order; none are dropped or duplicated under any out_ready pattern.
- Simultaneous output handshake and input accept in one cycle is legal and preserves full throughput.
- a/b/c_in/sub are ignored when in_valid=0 or in_ready=0.
- WIDTH=4: a single stage, latency 1, arithmetic identical to the 4-bit adder.

Test Plan:
- WIDTH=16, a=16'hFFFF, b=16'h0001, c_in=1, sub=0, out_ready=1 -> after 4 cycles: out_valid=1, s=16'h0001, c_out=1, ovf=0, zero=0 (full-chain carry propagation).
- a=16'h7FFF, b=16'h0001, c_in=0, sub=0 -> s=16'h8000, c_out=0, ovf=1, zero=0.
- Subtract:
  - a=16'h0005, b=16'h0005, sub=1, c_in=0 -> s=16'h0000, zero=1, c_out=1, ovf=0.
  - Then a=16'h0003, b=16'h0005, sub=1 -> s=16'hFFFE, c_out=0, ovf=0.
- Stream 8 back-to-back random operations while toggling out_ready (pattern 1,0,0,1,1,0,1,1...) -> results match a scoreboard in order; outputs are stable while stalled; in_ready=0 exactly when out_valid && !out_ready.
- Accept 3 operations, assert rst for 1 cycle on the 2nd cycle -> out_valid=0 and all outputs 0 the next cycle; no result from those 3 operations ever appears; a new operation after reset completes normally in 4 cycles.
- WIDTH=4 instance, a=4'b1111, b=4'b0001, c_in=1 -> 1 cycle later s=4'b0001, c_out=1; a=6, b=5, c_in=0 -> s=11, c_out=0; a=9, b=5, c_in=1 -> s=15, c_out=0.

Source files
------------

// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit lookahead block per stage,
// block carry registered between stages, single valid/ready stall for the whole pipe.
module cla_pipelined_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int N = WIDTH / 4;

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic             src_v;
        logic             src_c;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic [3:0]       g;
        logic [3:0]       p;
        logic [3:0]       sum;
        logic [4:0]       cy;
        logic [WIDTH-1:0] nxt_s;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_src
            // Subtraction folds into an add of ~b with the borrow flipped into a carry.
            assign src_v = in_valid;
            assign src_c = c_in ^ sub;
            assign src_a = a;
            assign src_b = sub ? ~b : b;
            assign src_s = '0;
        end else begin : g_src
            assign src_v = g_stage[k-1].v_q;
            assign src_c = g_stage[k-1].c_q;
            assign src_a = g_stage[k-1].g_ops.a_q;
            assign src_b = g_stage[k-1].g_ops.b_q;
            assign src_s = g_stage[k-1].s_q;
        end

        assign g = src_a[4*k +: 4] & src_b[4*k +: 4];
        assign p = src_a[4*k +: 4] ^ src_b[4*k +: 4];

        assign cy[0] = src_c;
        assign cy[1] = g[0] | (p[0] & cy[0]);
        assign cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cy[0]);
        assign cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & cy[0]);
        assign cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]) | ((&p) & cy[0]);
        assign sum   = p ^ cy[3:0];

        always_comb begin
            nxt_s = src_s;
            nxt_s[4*k +: 4] = sum;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= src_v;
                c_q <= cy[4];
                s_q <= nxt_s;
            end
        end

        if (k < N - 1) begin : g_ops
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= src_a;
                    b_q <= src_b;
                end
            end
        end else begin : g_flags
            logic ovf_q;
            logic zero_q;

            // cy[3] is the carry into the MSB, cy[4] the carry out of it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= cy[4] ^ cy[3];
                    zero_q <= (nxt_s == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[N-1].v_q;
    assign s         = g_stage[N-1].s_q;
    assign c_out     = g_stage[N-1].c_q;
    assign ovf       = g_stage[N-1].g_flags.ovf_q;
    assign zero      = g_stage[N-1].g_flags.zero_q;

endmodule
